// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz raster constants and the sync bundle carried through the alignment delay line.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // hs/vs are "asserted" flags, independent of pin polarity.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_bundle_t;

  localparam sync_bundle_t SyncIdle = '{active: 1'b0, hs: 1'b0, vs: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register, DEPTH stages of WIDTH bits, synchronous reset to RESET_VALUE.
module vga_delay_line #(
  parameter int unsigned       DEPTH       = 1,
  parameter int unsigned       WIDTH       = 3,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, pixel coordinates, and sync/blanking aligned to the picture ROM latency.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pix_en_i,
  input  logic [11:0] rgb_in_i,
  output logic [9:0]  pix_x_o,
  output logic [8:0]  pix_y_o,
  output logic        pix_valid_o,
  output logic        frame_start_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [3:0]  vga_r_o,
  output logic [3:0]  vga_g_o,
  output logic [3:0]  vga_b_o
);

  logic [9:0]   h_cnt_q, h_cnt_d;
  logic [9:0]   v_cnt_q, v_cnt_d;
  logic [9:0]   pix_x_q;
  logic [8:0]   pix_y_q;
  logic         frame_start_q;
  logic         hsync_q, vsync_q;
  logic [11:0]  rgb_q;
  logic         at_origin;
  sync_bundle_t raw, bundle_q, tap;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == 10'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == 10'(V_TOTAL - 1)) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    raw        = SyncIdle;
    raw.active = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
    raw.hs     = (h_cnt_q >= 10'(HS_START)) && (h_cnt_q < 10'(HS_END));
    raw.vs     = (v_cnt_q >= 10'(VS_START)) && (v_cnt_q < 10'(VS_END));
  end

  assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

  // frame_start is a one-clk pulse, so it is refreshed every clk rather than held on idle clks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      bundle_q      <= SyncIdle;
      frame_start_q <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      rgb_q         <= '0;
    end else begin
      frame_start_q <= pix_en_i && at_origin;
      if (pix_en_i) begin
        h_cnt_q  <= h_cnt_d;
        v_cnt_q  <= v_cnt_d;
        pix_x_q  <= raw.active ? h_cnt_q : '0;
        pix_y_q  <= raw.active ? v_cnt_q[8:0] : '0;
        bundle_q <= raw;
        hsync_q  <= tap.hs ? SYNC_POL : ~SYNC_POL;
        vsync_q  <= tap.vs ? SYNC_POL : ~SYNC_POL;
        rgb_q    <= tap.active ? rgb_in_i : '0;
      end
    end
  end

  // The registered bundle lines up with pix_x/pix_y; the delay line then matches the ROM latency.
  vga_delay_line #(
    .DEPTH      (PIPE_DELAY),
    .WIDTH      ($bits(sync_bundle_t)),
    .RESET_VALUE(SyncIdle)
  ) u_align (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (pix_en_i),
    .d_i  (bundle_q),
    .q_o  (tap)
  );

  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign pix_valid_o   = bundle_q.active;
  assign frame_start_o = frame_start_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign vga_r_o       = rgb_q[11:8];
  assign vga_g_o       = rgb_q[7:4];
  assign vga_b_o       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two DUTs (delay 1 active-low, delay 3 active-high) fed by modelled picture ROMs.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        valid;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } obs_t;

  localparam int unsigned DA = 1;
  localparam logic        PA = 1'b0;
  localparam int unsigned DB = 3;
  localparam logic        PB = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [11:0] rgb_a, rgb_b;
  logic [9:0]  x_a, x_b;
  logic [8:0]  y_a, y_b;
  logic        val_a, val_b, fs_a, fs_b, hs_a, hs_b, vs_a, vs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  vga_timing_gen #(.SYNC_POL(PA), .PIPE_DELAY(DA)) dut_a (
    .clk_i(clk), .rst_i(rst), .pix_en_i(pix_en), .rgb_in_i(rgb_a),
    .pix_x_o(x_a), .pix_y_o(y_a), .pix_valid_o(val_a), .frame_start_o(fs_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .vga_r_o(r_a), .vga_g_o(g_a), .vga_b_o(b_a)
  );

  vga_timing_gen #(.SYNC_POL(PB), .PIPE_DELAY(DB)) dut_b (
    .clk_i(clk), .rst_i(rst), .pix_en_i(pix_en), .rgb_in_i(rgb_b),
    .pix_x_o(x_b), .pix_y_o(y_b), .pix_valid_o(val_b), .frame_start_o(fs_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .vga_r_o(r_b), .vga_g_o(g_b), .vga_b_o(b_b)
  );

  // Picture ROM model: pattern inside the active region, white elsewhere (must be blanked).
  function automatic logic [11:0] rom_f(input logic [9:0] x, input logic [8:0] y, input logic v);
    return v ? {x[3:0], y[3:0], 4'hA} : 12'hFFF;
  endfunction

  logic [11:0] rom_a_q;
  logic [11:0] rom_b_q [3];

  initial begin
    rom_a_q = '0;
    for (int i = 0; i < 3; i++) rom_b_q[i] = '0;
  end

  always @(posedge clk) begin
    if (pix_en) begin
      rom_a_q    <= rom_f(x_a, y_a, val_a);
      rom_b_q[0] <= rom_f(x_b, y_b, val_b);
      rom_b_q[1] <= rom_b_q[0];
      rom_b_q[2] <= rom_b_q[1];
    end
  end

  assign rgb_a = rom_a_q;
  assign rgb_b = rom_b_q[2];

  obs_t act_a, act_b;
  assign act_a = {x_a, y_a, val_a, fs_a, hs_a, vs_a, r_a, g_a, b_a};
  assign act_b = {x_b, y_b, val_b, fs_b, hs_b, vs_b, r_b, g_b, b_b};

  // Expected observation after the strobe presenting raster position p (p = 0 right after reset).
  function automatic obs_t expect_at(input int p, input int d, input logic pol);
    obs_t e;
    int h, v, q, hq, vq;
    logic [9:0] hb, vb;
    logic act;
    h  = p % 800;
    v  = (p / 800) % 525;
    hb = h[9:0];
    vb = v[9:0];
    act = (h < 640) && (v < 480);
    e.valid = act;
    e.x  = act ? hb : 10'd0;
    e.y  = act ? vb[8:0] : 9'd0;
    e.fs = (p % 420000) == 0;
    e.hs = ~pol;
    e.vs = ~pol;
    e.rgb = 12'h000;
    q = p - d - 1;
    if (q >= 0) begin
      hq = q % 800;
      vq = (q / 800) % 525;
      hb = hq[9:0];
      vb = vq[9:0];
      if (hq >= 656 && hq < 752) e.hs = pol;
      if (vq >= 490 && vq < 492) e.vs = pol;
      if (hq < 640 && vq < 480) e.rgb = {hb[3:0], vb[3:0], 4'hA};
    end
    return e;
  endfunction

  function automatic obs_t reset_obs(input logic pol);
    obs_t e;
    e = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    return e;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got x=%0d y=%0d v=%0b fs=%0b hs=%0b vs=%0b rgb=%03h want x=%0d y=%0d v=%0b fs=%0b hs=%0b vs=%0b rgb=%03h",
               name, $time, act.x, act.y, act.valid, act.fs, act.hs, act.vs, act.rgb,
               exp.x, exp.y, exp.valid, exp.fs, exp.hs, exp.vs, exp.rgb);
    end
  endtask

  obs_t q_a[$];
  obs_t q_b[$];
  int   s = 0;

  // Monitor: classify each clk edge, then compare just after it.
  obs_t last_a, last_b, hold_e;
  logic en_s, rst_s;

  always @(posedge clk) begin
    en_s  = pix_en && !rst;
    rst_s = rst;
    #1;
    if (rst_s) begin
      last_a = reset_obs(PA);
      last_b = reset_obs(PB);
      check("reset_a", act_a, last_a);
      check("reset_b", act_b, last_b);
    end else if (en_s) begin
      if (q_a.size() == 0 || q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t got sizes %0d/%0d want nonzero", $time,
                 q_a.size(), q_b.size());
      end else begin
        last_a = q_a.pop_front();
        last_b = q_b.pop_front();
        check("strobe_a", act_a, last_a);
        check("strobe_b", act_b, last_b);
      end
    end else begin
      hold_e = last_a; hold_e.fs = 1'b0;
      check("hold_a", act_a, hold_e);
      hold_e = last_b; hold_e.fs = 1'b0;
      check("hold_b", act_b, hold_e);
    end
  end

  task automatic tick(input logic en, input logic r);
    @(negedge clk);
    rst    = r;
    pix_en = en;
    if (r) begin
      s = 0;
    end else if (en) begin
      q_a.push_back(expect_at(s, DA, PA));
      q_b.push_back(expect_at(s, DB, PB));
      s++;
    end
  endtask

  initial begin
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    // Strobe every clk: 40 full lines with hsync pulses, pattern and blanking checks.
    repeat (32000) tick(1'b1, 1'b0);
    // One strobe in four, crossing line wraps with idle clks at the boundary.
    repeat (2000) begin
      tick(1'b1, 1'b0);
      repeat (3) tick(1'b0, 1'b0);
    end
    // Reset mid-line with pix_en also high: reset must win and the delay line must flush.
    while (s % 800 != 300) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    repeat (2000) tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    n_tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got sizes %0d/%0d want 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
